oam_dma: RTL

- OAM DMA controller and bus arbiter between the sm83 CPU port and the system memory bus (ROM/boot, VRAM, WRAM, PPU regs).
- A CPU write to 0xFF46 starts a copy of LEN bytes from {src_hi,8'h00} to the OAM write port, one byte per M-cycle.
- While the copy runs, the block owns the system bus and gates the CPU.
- Sits between cpu and the top-level casex decode; drives the ppu OAM write port.

---
 rtl/dmg_pkg.sv | 55 +++++
 rtl/oam_dma_if.sv | 42 ++++
 rtl/oam_dma.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/dmg_pkg.sv
//------------------------------------------------------------------------------
// dmg_pkg
// Shared types and constants for the DMG system bus: DMA FSM states, the
// DMA trigger register address, OAM size and the address-region decode used
// by both the OAM DMA block and the top-level memory decode.
//------------------------------------------------------------------------------
`default_nettype none

package dmg_pkg;

   // OAM DMA controller states
   typedef enum logic [1:0] {
      DMA_IDLE  = 2'd0,
      DMA_START = 2'd1,
      DMA_XFER  = 2'd2
   } dma_state_t;

   localparam logic [15:0] ADDR_DMA = 16'hFF46;
   localparam int          OAM_LEN  = 160;

   // System address regions, in the order the top-level decode checks them
   typedef enum logic [2:0] {
      RGN_ROM      = 3'd0,   // 0000-7FFF cartridge ROM / boot ROM
      RGN_VRAM     = 3'd1,   // 8000-9FFF
      RGN_CART_RAM = 3'd2,   // A000-BFFF
      RGN_WRAM     = 3'd3,   // C000-DFFF
      RGN_ECHO     = 3'd4,   // E000-FDFF mirror of WRAM
      RGN_OAM      = 3'd5,   // FE00-FE9F (and the unusable hole up to FEFF)
      RGN_IO       = 3'd6,   // FF00-FF7F, FFFF
      RGN_HRAM     = 3'd7    // FF80-FFFE
   } addr_region_t;

   // Classify a CPU/bus address into its memory region
   function automatic addr_region_t decode_region(input logic [15:0] addr);
      addr_region_t rgn;
      if (addr[15] == 1'b0)               rgn = RGN_ROM;
      else if (addr[15:13] == 3'b100)     rgn = RGN_VRAM;
      else if (addr[15:13] == 3'b101)     rgn = RGN_CART_RAM;
      else if (addr[15:13] == 3'b110)     rgn = RGN_WRAM;
      else if (addr[15:8] < 8'hFE)        rgn = RGN_ECHO;
      else if (addr[15:8] == 8'hFE)       rgn = RGN_OAM;
      else if (addr == 16'hFFFF)          rgn = RGN_IO;
      else if (addr[7] == 1'b1)           rgn = RGN_HRAM;
      else                                rgn = RGN_IO;
      return rgn;
   endfunction

   // DMA source pages E0..FF alias back onto WRAM (C0..DF)
   function automatic logic [7:0] fold_src_hi(input logic [7:0] src_hi);
      return (src_hi >= 8'hE0) ? (src_hi & 8'hDF) : src_hi;
   endfunction

endpackage

`default_nettype wire

// File: rtl/oam_dma_if.sv
//------------------------------------------------------------------------------
// oam_dma_if
// CPU port, system bus port and OAM write port of the OAM DMA controller.
// master: the DMA/arbiter side. slave: CPU, memory decode and PPU side.
//------------------------------------------------------------------------------
`default_nettype none

interface oam_dma_if;

   // CPU side
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_d_out;
   logic        cpu_write;
   logic [7:0]  cpu_d_in;

   // System bus side
   logic [15:0] bus_addr;
   logic        bus_write;
   logic [7:0]  bus_d_wr;
   logic [7:0]  bus_d_rd;

   // PPU OAM write port and status
   logic [7:0]  oam_addr;
   logic [7:0]  oam_d_wr;
   logic        oam_write;
   logic        dma_active;

   modport master (
      input  cpu_addr, cpu_d_out, cpu_write, bus_d_rd,
      output cpu_d_in, bus_addr, bus_write, bus_d_wr,
      output oam_addr, oam_d_wr, oam_write, dma_active
   );

   modport slave (
      output cpu_addr, cpu_d_out, cpu_write, bus_d_rd,
      input  cpu_d_in, bus_addr, bus_write, bus_d_wr,
      input  oam_addr, oam_d_wr, oam_write, dma_active
   );

endinterface

`default_nettype wire

// File: rtl/oam_dma.sv
//------------------------------------------------------------------------------
// oam_dma
// OAM DMA controller and CPU/system-bus arbiter. A CPU write to the DMA
// register copies LEN bytes from page {src_hi,00} into OAM, one byte per
// M-cycle, while the CPU is cut off from the bus.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module oam_dma
   import dmg_pkg::*;
#(
   parameter int          LEN         = OAM_LEN,
   parameter int          START_DELAY = 1,
   parameter logic [15:0] DMA_REG     = ADDR_DMA
) (
   input  wire logic  clk,
   input  wire logic  rst,       // asynchronous, active low
   input  wire logic  ce,        // M-cycle enable
   oam_dma_if.master  bus
);

   localparam logic [7:0] LAST_IDX   = 8'(LEN - 1);
   localparam logic [7:0] DELAY_INIT = 8'(START_DELAY);

   dma_state_t  state_q, state_d;
   logic [7:0]  src_hi_q, src_hi_d;
   logic [7:0]  idx_q, idx_d;
   logic [7:0]  delay_q, delay_d;
   logic        oam_write_q, oam_write_d;
   logic [7:0]  oam_addr_q, oam_addr_d;
   logic [7:0]  oam_d_wr_q, oam_d_wr_d;
   logic        dma_active_q, dma_active_d;

   logic        reg_hit;
   logic        trigger;
   logic [7:0]  eff_hi;

   logic [15:0] bus_addr_c;
   logic        bus_write_c;
   logic [7:0]  bus_d_wr_c;
   logic [7:0]  cpu_d_in_c;

   assign reg_hit = (bus.cpu_addr == DMA_REG);
   assign trigger = ce & bus.cpu_write & reg_hit;
   assign eff_hi  = fold_src_hi(src_hi_q);

   // Next-state logic: FSM stepping, byte copy and (re)trigger on each M-cycle
   always_comb begin
      state_d      = state_q;
      src_hi_d     = src_hi_q;
      idx_d        = idx_q;
      delay_d      = delay_q;
      oam_write_d  = 1'b0;
      oam_addr_d   = oam_addr_q;
      oam_d_wr_d   = oam_d_wr_q;
      dma_active_d = dma_active_q;

      if (ce) begin
         case (state_q)
            DMA_START: begin
               if (delay_q <= 8'd1) begin
                  state_d = DMA_XFER;
                  idx_d   = 8'd0;
                  delay_d = 8'd0;
               end else begin
                  delay_d = delay_q - 8'd1;
               end
            end
            DMA_XFER: begin
               oam_write_d = 1'b1;
               oam_addr_d  = idx_q;
               oam_d_wr_d  = bus.bus_d_rd;
               if (idx_q == LAST_IDX) begin
                  state_d      = DMA_IDLE;
                  idx_d        = 8'd0;
                  dma_active_d = 1'b0;
               end else begin
                  idx_d = idx_q + 8'd1;
               end
            end
            default: ;
         endcase

         // A register write (re)starts the copy; a byte in flight on this
         // same M-cycle still lands using the old source page.
         if (trigger) begin
            src_hi_d     = bus.cpu_d_out;
            idx_d        = 8'd0;
            dma_active_d = 1'b1;
            if (START_DELAY == 0) begin
               state_d = DMA_XFER;
               delay_d = 8'd0;
            end else begin
               state_d = DMA_START;
               delay_d = DELAY_INIT;
            end
         end
      end
   end

   // State and output registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= DMA_IDLE;
         src_hi_q     <= 8'h00;
         idx_q        <= 8'd0;
         delay_q      <= 8'd0;
         oam_write_q  <= 1'b0;
         oam_addr_q   <= 8'd0;
         oam_d_wr_q   <= 8'd0;
         dma_active_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         src_hi_q     <= src_hi_d;
         idx_q        <= idx_d;
         delay_q      <= delay_d;
         oam_write_q  <= oam_write_d;
         oam_addr_q   <= oam_addr_d;
         oam_d_wr_q   <= oam_d_wr_d;
         dma_active_q <= dma_active_d;
      end
   end

   // Bus arbitration: CPU passes through when idle, DMA owns the bus otherwise;
   // the DMA register is always served locally and never reaches the bus.
   always_comb begin
      bus_addr_c  = bus.cpu_addr;
      bus_write_c = bus.cpu_write;
      bus_d_wr_c  = bus.cpu_d_out;
      cpu_d_in_c  = bus.bus_d_rd;

      if (state_q != DMA_IDLE) begin
         bus_addr_c  = {eff_hi, idx_q};
         bus_write_c = 1'b0;
         bus_d_wr_c  = 8'h00;
         cpu_d_in_c  = 8'hFF;
      end

      if (reg_hit) begin
         bus_write_c = 1'b0;
         cpu_d_in_c  = src_hi_q;
      end
   end

   assign bus.bus_addr   = bus_addr_c;
   assign bus.bus_write  = bus_write_c;
   assign bus.bus_d_wr   = bus_d_wr_c;
   assign bus.cpu_d_in   = cpu_d_in_c;
   assign bus.oam_write  = oam_write_q;
   assign bus.oam_addr   = oam_addr_q;
   assign bus.oam_d_wr   = oam_d_wr_q;
   assign bus.dma_active = dma_active_q;

endmodule

`default_nettype wire
